knowles_pipe_adder: RTL and testbench

KNOWLES_PIPE_ADDER -- requirements
Module: knowles_pipe_adder

---
 rtl/knowles_pipe_adder.sv | 101 ++++++++++
 tb/tb_knowles_pipe_adder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/knowles_pipe_adder.sv
// Pipelined Kogge-Stone (Knowles 1,1,...,1) adder: one prefix level per stage, valid/ready flow.
// Define KNOWLES_OVF_EN to add the registered signed-overflow output Ovf.
module knowles_pipe_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef KNOWLES_OVF_EN
    ,
    output logic             Ovf
`endif
);
    localparam int unsigned LEVELS = $clog2(WIDTH);

    logic             stall;
    logic [LEVELS:0]  v_q;
    logic [LEVELS:0]  cin_q;
    logic [WIDTH-1:0] g_q  [LEVELS+1];
    logic [WIDTH-1:0] g_d  [LEVELS+1];
    // Group propagate is dead after the last level, so it stops one stage early.
    logic [WIDTH-1:0] pg_q [LEVELS];
    logic [WIDTH-1:0] pg_d [LEVELS];
    logic [WIDTH-1:0] p_q  [LEVELS+1];
    logic [WIDTH-1:0] carry;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    always_comb begin
        g_d[0]    = A & B;
        g_d[0][0] = (A[0] & B[0]) | ((A[0] ^ B[0]) & Cin);
        pg_d[0]   = A ^ B;
        for (int unsigned k = 1; k <= LEVELS; k++) begin
            g_d[k] = g_q[k-1];
            for (int unsigned i = (32'd1 << (k - 1)); i < WIDTH; i++) begin
                g_d[k][i] = g_q[k-1][i] | (pg_q[k-1][i] & g_q[k-1][i-(32'd1 << (k - 1))]);
            end
        end
        for (int unsigned k = 1; k < LEVELS; k++) begin
            pg_d[k] = pg_q[k-1];
            for (int unsigned i = (32'd1 << (k - 1)); i < WIDTH; i++) begin
                pg_d[k][i] = pg_q[k-1][i] & pg_q[k-1][i-(32'd1 << (k - 1))];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
        end else if (!stall) begin
            v_q <= {v_q[LEVELS-1:0], in_valid};
        end
    end

    // Data registers need no reset: only the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (!stall) begin
            for (int unsigned k = 0; k <= LEVELS; k++) begin
                g_q[k] <= g_d[k];
            end
            for (int unsigned k = 0; k < LEVELS; k++) begin
                pg_q[k] <= pg_d[k];
            end
            p_q[0] <= A ^ B;
            for (int unsigned k = 1; k <= LEVELS; k++) begin
                p_q[k] <= p_q[k-1];
            end
            cin_q <= {cin_q[LEVELS-1:0], Cin};
        end
    end

    // carry[i] is the carry into bit i.
    assign carry = {g_q[LEVELS][WIDTH-2:0], cin_q[LEVELS]};

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            S         <= '0;
            Cout      <= 1'b0;
`ifdef KNOWLES_OVF_EN
            Ovf       <= 1'b0;
`endif
        end else if (!stall) begin
            out_valid <= v_q[LEVELS];
            S         <= p_q[LEVELS] ^ carry;
            Cout      <= g_q[LEVELS][WIDTH-1];
`ifdef KNOWLES_OVF_EN
            Ovf       <= carry[WIDTH-1] ^ g_q[LEVELS][WIDTH-1];
`endif
        end
    end
endmodule

// File: tb/tb_knowles_pipe_adder.sv
// Scoreboard bench for knowles_pipe_adder: 32-bit directed, stall and reset cases, 8-bit vectors.
// Ovf is compared only when KNOWLES_OVF_EN is defined.
module tb_knowles_pipe_adder;
    typedef struct packed {
        logic        lat;
        logic [31:0] acc;
        logic [31:0] s;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] A, B, S;
    logic        Cin, Cout, Ovf;
    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  a8, b8, s8;
    logic        cin8, cout8, ovf8;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   stall_seen = 0;
    logic done = 1'b0;
    logic rst_prev = 1'b1;
    logic stalled_prev = 1'b0;
    logic [31:0] hold_s;
    logic        hold_c;
    exp_t exp_q[$];
    exp_t q8[$];
    exp_t e;

    knowles_pipe_adder #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .Cout(Cout)
`ifdef KNOWLES_OVF_EN
        , .Ovf(Ovf)
`endif
    );

    knowles_pipe_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .A(a8), .B(b8), .Cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .S(s8), .Cout(cout8)
`ifdef KNOWLES_OVF_EN
        , .Ovf(ovf8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic c,
                          input logic [31:0] es, input logic ec, input logic eo, input logic lat);
        logic take;
        take = 1'b0;
        A = a; B = b; Cin = c; in_valid = 1'b1;
        for (int t = 0; t < 200 && !take; t++) begin
            @(negedge clk);
            take = in_ready;
            @(posedge clk);
            #1;
        end
        exp_q.push_back('{lat, cyc - 1, es, ec, eo});
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [7:0] es, input logic ec, input logic eo, input logic lat);
        logic take;
        take = 1'b0;
        a8 = a; b8 = b; cin8 = c; in_valid8 = 1'b1;
        for (int t = 0; t < 200 && !take; t++) begin
            @(negedge clk);
            take = in_ready8;
            @(posedge clk);
            #1;
        end
        q8.push_back('{lat, cyc - 1, {24'd0, es}, ec, eo});
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        in_valid8 = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] ra, rb, rs;
        logic       rc, rco;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; Cin = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // Isolated directed beats, latency checked.
        send32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1); idle(10);
        send32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1); idle(10);
        send32(32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1); idle(10);
        send32(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1); idle(10);
        send32(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'hACF1_3569, 1'b0, 1'b0, 1'b1); idle(10);
        send32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1); idle(10);
        send32(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1); idle(10);
        send32(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1); idle(10);

        // Back-to-back beats with the consumer stalling mid-stream.
        fork
            begin
                for (int n = 0; n < 10; n++) begin
                    send32(n, 3 * n, n[0], 4 * n + n[0], 1'b0, 1'b0, 1'b0);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (8) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(20);

        // Three beats in flight, then reset; an offered beat during reset is also dropped.
        send32(32'h1111_1111, 32'h1, 1'b0, 32'h1111_1112, 1'b0, 1'b0, 1'b0);
        send32(32'h2222_2222, 32'h2, 1'b0, 32'h2222_2224, 1'b0, 1'b0, 1'b0);
        send32(32'h3333_3333, 32'h3, 1'b0, 32'h3333_3336, 1'b0, 1'b0, 1'b0);
        rst = 1'b1; A = 32'hDEAD_BEEF; B = 32'h1; in_valid = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        idle(20);

        // 8-bit instance: directed latency beat, then back-to-back vectors against a reference.
        send8(8'hA5, 8'h5B, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1); idle(8);
        for (int n = 0; n < 300; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            {rco, rs} = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            send8(ra, rb, rc, rs, rco, (ra[7] == rb[7]) && (rs[7] != ra[7]), 1'b0);
        end
        idle(15);
        done = 1'b1;
    end

    always @(negedge clk) begin
        if (done || cyc > 30000) begin
            if (!done) begin
                errors++;
                $display("FAIL timeout: got cycle %0d want completion", cyc);
            end
            chk("q32_drained", exp_q.size(), 0);
            chk("q8_drained", q8.size(), 0);
            chk("stall_seen", stall_seen != 0, 1);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end else if (rst) begin
            stalled_prev = 1'b0;
        end else begin
            if (rst_prev) begin
                chk("rst_out_valid", out_valid, 0);
                chk("rst_s", S, 0);
                chk("rst_cout", Cout, 0);
                chk("rst_in_ready", in_ready, 1);
                chk("rst_out_valid8", out_valid8, 0);
`ifdef KNOWLES_OVF_EN
                chk("rst_ovf", Ovf, 0);
`endif
            end
            if (stalled_prev) begin
                chk("stall_valid_hold", out_valid, 1);
                chk("stall_s_hold", S, hold_s);
                chk("stall_cout_hold", Cout, hold_c);
            end
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", in_ready, 0);
                hold_s = S;
                hold_c = Cout;
                stalled_prev = 1'b1;
                stall_seen++;
            end else begin
                stalled_prev = 1'b0;
            end
            if (out_valid && out_ready) begin
                chk("beat32_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("s32", S, e.s);
                    chk("cout32", Cout, e.cout);
`ifdef KNOWLES_OVF_EN
                    chk("ovf32", Ovf, e.ovf);
`endif
                    if (e.lat) chk("latency32", cyc - e.acc, 7);
                end
            end
            if (out_valid8) begin
                chk("beat8_expected", q8.size() != 0, 1);
                if (q8.size() != 0) begin
                    e = q8.pop_front();
                    chk("s8", s8, e.s[7:0]);
                    chk("cout8", cout8, e.cout);
`ifdef KNOWLES_OVF_EN
                    chk("ovf8", ovf8, e.ovf);
`endif
                    if (e.lat) chk("latency8", cyc - e.acc, 5);
                end
            end
        end
        rst_prev = rst;
    end
endmodule
